// File: rtl/memory_responder.sv
// Wait-state word memory behind a simple CPU request/ack handshake.
// One access at a time: sampled in IDLE, completed WAIT_STATES+1 clocks later with a one-cycle ack.
module memory_responder #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         request,
  input  logic         write_enable,
  input  logic [0:3]   byte_enable,
  input  logic [15:31] memory_address,
  input  logic [0:31]  write_data,
  output logic [0:31]  memory_data_in,
  output logic         ack,
  output logic         error,
  output logic         busy
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_count;

  // Request captured at acceptance; inputs are ignored until the access retires.
  logic                  r_we;
  logic [3:0]            r_be;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata;

  logic [31:0]           r_rdata;
  logic                  r_error;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_fire;
  logic                  w_out_of_range;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_ack;

  assign w_accept       = (r_state == S_IDLE) && request;
  // WAIT spans WAIT_STATES+1 clocks, so the completing edge is WAIT_STATES+1 edges after sampling.
  assign w_fire         = (r_state == S_WAIT) && (r_count == 4'd0);
  assign w_out_of_range = |(r_addr >> DEPTH_LOG2);
  assign w_index        = r_addr[DEPTH_LOG2-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (request) w_next_state = S_WAIT;
      S_WAIT:    if (r_count == 4'd0) w_next_state = S_RESPOND;
      S_RESPOND: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= 4'd0;
    end else if (w_accept) begin
      r_count <= 4'(WAIT_STATES);
    end else if ((r_state == S_WAIT) && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= write_enable;
      r_be    <= byte_enable;
      r_addr  <= memory_address;
      r_wdata <= write_data;
    end
  end

  // Read data only moves on a completing read; out-of-range reads return zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else if (w_fire) begin
      r_error <= w_out_of_range;
      if (!r_we) begin
        r_rdata <= w_out_of_range ? 32'd0 : r_mem[w_index];
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and an aborted access never fires.
  always_ff @(posedge clock) begin
    if (w_fire && r_we && !w_out_of_range) begin
      if (r_be[3]) r_mem[w_index][31:24] <= r_wdata[31:24];
      if (r_be[2]) r_mem[w_index][23:16] <= r_wdata[23:16];
      if (r_be[1]) r_mem[w_index][15:8]  <= r_wdata[15:8];
      if (r_be[0]) r_mem[w_index][7:0]   <= r_wdata[7:0];
    end
  end

  assign w_ack          = (r_state == S_RESPOND);
  assign ack            = w_ack;
  assign busy           = (r_state != S_IDLE);
  assign error          = w_ack && r_error;
  assign memory_data_in = r_rdata;

endmodule
